// File: rtl/weight_bank_loader.sv
// Write-side loader for the weight register bank: takes weights over valid/ready and
// writes them to addresses 0..NUM_WEIGHTS-1 with a setup / strobe / hold sequence each.
module weight_bank_loader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned NUM_WEIGHTS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        StIdle,
        StAccept,
        StSetup,
        StWrite,
        StHold,
        StDone
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_WEIGHTS - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StAccept;
                end
            end
            StAccept: begin
                // A completed handshake always consumes the weight, even if aborted.
                if (in_valid) begin
                    data_d  = in_data;
                    state_d = StSetup;
                end
            end
            StSetup: state_d = StWrite;
            StWrite: state_d = StHold;
            StHold: begin
                if (addr_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StAccept;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
        end
        if (state_d == StIdle) begin
            addr_d = '0;
        end
    end

    // Outputs are flopped from the next state so they leave the block glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            data_q   <= '0;
            addr_q   <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            in_ready <= (state_d == StAccept);
            wr_en    <= (state_d == StWrite);
            busy     <= (state_d == StAccept) || (state_d == StSetup) ||
                        (state_d == StWrite)  || (state_d == StHold);
            done     <= (state_d == StDone);
        end
    end

    assign wr_data = data_q;
    assign wr_addr = addr_q;

endmodule
